// File: rtl/arith.sv
// arith: 16-bit two-operand ALU (add/sub/mul/div/mod/shl/shr/cmp), 32-bit result plus divide-by-zero flag.
// Latency: exactly 1 cycle from in_valid to out_valid; a new operation can be accepted every cycle.
// Backpressure: none; result and flag hold while in_valid is low. Define ARITH_SIGNED_EN for two's-complement operands.
module arith (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [2:0]  opcode,
    output logic [31:0] outau,
    output logic        out_valid,
    output logic        div_by_zero
);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_MUL = 3'b010,
        OP_DIV = 3'b011,
        OP_MOD = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_CMP = 3'b111
    } op_t;

    logic [31:0] outau_q, outau_d;
    logic        out_valid_q, out_valid_d;
    logic        div_by_zero_q, div_by_zero_d;

    // Operands widened to 32 bits once, so every operation below works at
    // result width. In signed mode the widening is a sign extension, which
    // makes the low 32 bits of add/sub/mul the correctly signed results.
    logic [31:0] a_ext;
    logic [31:0] b_ext;
    logic [31:0] b_div;
    logic [4:0]  sh_amt;
    logic        b_zero;
    logic [31:0] quot;
    logic [31:0] rem;
    logic [31:0] shr_res;
    logic        a_lt_b;
    logic        a_gt_b;

    // Operand preparation, division and the mode-dependent operations.
    // The divisor is forced to 1 when b is zero so the divider never sees
    // a zero divisor; the zero case is patched in the result mux instead.
    always_comb begin
        sh_amt = b[4:0];
        b_zero = (b == 16'h0000);
`ifdef ARITH_SIGNED_EN
        a_ext   = {{16{a[15]}}, a};
        b_ext   = {{16{b[15]}}, b};
        b_div   = b_zero ? 32'd1 : b_ext;
        // 32-bit signed division makes -32768 / -1 come out as +32768.
        quot    = $signed(a_ext) / $signed(b_div);
        rem     = $signed(a_ext) % $signed(b_div);
        shr_res = $signed(a_ext) >>> sh_amt;
        a_lt_b  = $signed(a) < $signed(b);
        a_gt_b  = $signed(a) > $signed(b);
`else
        a_ext   = {16'h0000, a};
        b_ext   = {16'h0000, b};
        b_div   = b_zero ? 32'd1 : b_ext;
        quot    = a_ext / b_div;
        rem     = a_ext % b_div;
        shr_res = a_ext >> sh_amt;
        a_lt_b  = a < b;
        a_gt_b  = a > b;
`endif
    end

    // Next-state: capture a new result when in_valid, otherwise hold.
    always_comb begin
        outau_d       = outau_q;
        div_by_zero_d = div_by_zero_q;
        out_valid_d   = in_valid;
        if (in_valid) begin
            div_by_zero_d = 1'b0;
            case (op_t'(opcode))
                OP_ADD: outau_d = a_ext + b_ext;
                OP_SUB: outau_d = a_ext - b_ext;
                OP_MUL: outau_d = a_ext * b_ext;
                OP_DIV: begin
                    outau_d       = b_zero ? 32'hFFFF_FFFF : quot;
                    div_by_zero_d = b_zero;
                end
                OP_MOD: begin
                    // Divide-by-zero returns the dividend zero-extended in both modes.
                    outau_d       = b_zero ? {16'h0000, a} : rem;
                    div_by_zero_d = b_zero;
                end
                OP_SHL: outau_d = {16'h0000, a} << sh_amt;
                OP_SHR: outau_d = shr_res;
                OP_CMP: outau_d = {29'd0, a_gt_b, (a == b), a_lt_b};
                default: outau_d = 32'd0;
            endcase
        end
    end

    // Output registers; reset drops any in-flight result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outau_q       <= 32'd0;
            out_valid_q   <= 1'b0;
            div_by_zero_q <= 1'b0;
        end else begin
            outau_q       <= outau_d;
            out_valid_q   <= out_valid_d;
            div_by_zero_q <= div_by_zero_d;
        end
    end

    assign outau       = outau_q;
    assign out_valid   = out_valid_q;
    assign div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_arith.sv
// tb_arith: directed-vector bench for arith with hand-computed expectations.
// Inputs are driven 1 time unit after each rising edge; outputs are sampled at the same point.
// Expectations that differ between unsigned and ARITH_SIGNED_EN builds are selected at compile time.
module tb_arith;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  opcode;
    logic [31:0] outau;
    logic        out_valid;
    logic        div_by_zero;

    int checks   = 0;
    int failures = 0;

    arith dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .a           (a),
        .b           (b),
        .opcode      (opcode),
        .outau       (outau),
        .out_valid   (out_valid),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    // Sweep tables, indexed by opcode.
    logic [31:0] exp_sweep1 [8] = '{32'h0000_0011, 32'hFFFF_FFF1, 32'h0000_0010, 32'h0000_0000,
                                    32'h0000_0001, 32'h0001_0000, 32'h0000_0000, 32'h0000_0001};
    logic [31:0] exp_sweep2 [8] = '{32'h0000_0210, 32'hFFFF_FFF0, 32'h0001_1000, 32'h0000_0000,
                                    32'h0000_0100, 32'h0100_0000, 32'h0000_0000, 32'h0000_0001};

    // Single comparison point: counts every check and reports mismatches.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Present one input cycle, then step to just after the capturing edge.
    task automatic issue(input logic v, input logic [2:0] op, input logic [15:0] aa, input logic [15:0] bb);
        in_valid = v;
        opcode   = op;
        a        = aa;
        b        = bb;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_op(input string tag, input logic [2:0] op, input logic [15:0] aa,
                          input logic [15:0] bb, input logic [31:0] exp_res, input logic exp_dz);
        issue(1'b1, op, aa, bb);
        chk({tag, ".res"}, outau, exp_res);
        chk({tag, ".vld"}, {31'd0, out_valid}, 32'd1);
        chk({tag, ".dz"},  {31'd0, div_by_zero}, {31'd0, exp_dz});
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b1;
        opcode   = 3'($urandom_range(0, 7));
        a        = 16'($urandom);
        b        = 16'($urandom);

        // Reset held with live inputs: outputs stay cleared.
        repeat (3) @(posedge clk);
        #1;
        chk("rst.res", outau, 32'd0);
        chk("rst.vld", {31'd0, out_valid}, 32'd0);
        chk("rst.dz",  {31'd0, div_by_zero}, 32'd0);

        // Release mid-cycle: nothing changes before the next edge.
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        #2;
        chk("rel.res", outau, 32'd0);
        chk("rel.vld", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;

        // Back-to-back opcode sweeps.
        for (int i = 0; i < 8; i++)
            chk_op($sformatf("sw1.op%0d", i), 3'(i), 16'h0001, 16'h0010, exp_sweep1[i], 1'b0);
        for (int i = 0; i < 8; i++)
            chk_op($sformatf("sw2.op%0d", i), 3'(i), 16'h0100, 16'h0110, exp_sweep2[i], 1'b0);

        // Boundaries.
`ifdef ARITH_SIGNED_EN
        chk_op("bnd.add", 3'b000, 16'hFFFF, 16'hFFFF, 32'hFFFF_FFFE, 1'b0);
        chk_op("bnd.mul", 3'b010, 16'hFFFF, 16'hFFFF, 32'h0000_0001, 1'b0);
`else
        chk_op("bnd.add", 3'b000, 16'hFFFF, 16'hFFFF, 32'h0001_FFFE, 1'b0);
        chk_op("bnd.mul", 3'b010, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 1'b0);
`endif
        chk_op("bnd.cmp", 3'b111, 16'hFFFF, 16'hFFFF, 32'h0000_0002, 1'b0);
        chk_op("bnd.shl", 3'b101, 16'hFFFF, 16'd31,   32'h8000_0000, 1'b0);
        chk_op("bnd.cmpgt", 3'b111, 16'h0005, 16'h0003, 32'h0000_0004, 1'b0);

        // Divide by zero, then the flag must clear on the next op.
        chk_op("dz.div", 3'b011, 16'd5, 16'd0, 32'hFFFF_FFFF, 1'b1);
        chk_op("dz.mod", 3'b100, 16'd5, 16'd0, 32'h0000_0005, 1'b1);
        chk_op("dz.add", 3'b000, 16'd1, 16'd1, 32'h0000_0002, 1'b0);
        chk_op("div.nz", 3'b011, 16'd100, 16'd7, 32'h0000_000E, 1'b0);
        chk_op("mod.nz", 3'b100, 16'd100, 16'd7, 32'h0000_0002, 1'b0);

        // Mode-sensitive vectors.
`ifdef ARITH_SIGNED_EN
        chk_op("sg.mul", 3'b010, 16'hFFFF, 16'd2, 32'hFFFF_FFFE, 1'b0);
        chk_op("sg.cmp", 3'b111, 16'hFFFF, 16'd2, 32'h0000_0001, 1'b0);
        chk_op("sg.div", 3'b011, 16'hFFFF, 16'd2, 32'h0000_0000, 1'b0);
        chk_op("sg.shr", 3'b110, 16'h8000, 16'd1, 32'hFFFF_C000, 1'b0);
        chk_op("sg.ovf", 3'b011, 16'h8000, 16'hFFFF, 32'h0000_8000, 1'b0);
        chk_op("sg.mod", 3'b100, 16'hFFF9, 16'd2, 32'hFFFF_FFFF, 1'b0);
`else
        chk_op("us.mul", 3'b010, 16'hFFFF, 16'd2, 32'h0001_FFFE, 1'b0);
        chk_op("us.cmp", 3'b111, 16'hFFFF, 16'd2, 32'h0000_0004, 1'b0);
        chk_op("us.div", 3'b011, 16'hFFFF, 16'd2, 32'h0000_7FFF, 1'b0);
        chk_op("us.shr", 3'b110, 16'h8000, 16'd1, 32'h0000_4000, 1'b0);
        chk_op("us.div8", 3'b011, 16'h8000, 16'hFFFF, 32'h0000_0000, 1'b0);
        chk_op("us.mod", 3'b100, 16'hFFF9, 16'd2, 32'h0000_0001, 1'b0);
`endif

        // Valid gating 1,0,1: result and flag hold across the gap.
        chk_op("gate.v1", 3'b000, 16'd1, 16'd1, 32'h0000_0002, 1'b0);
        issue(1'b0, 3'b011, 16'd7, 16'd0);
        chk("gate.gap.vld", {31'd0, out_valid}, 32'd0);
        chk("gate.gap.res", outau, 32'h0000_0002);
        chk("gate.gap.dz",  {31'd0, div_by_zero}, 32'd0);
        chk_op("gate.v2", 3'b000, 16'd3, 16'd4, 32'h0000_0007, 1'b0);

        // Reset mid-stream clears asynchronously and drops the in-flight op.
        in_valid = 1'b1;
        opcode   = 3'b011;
        a        = 16'd9;
        b        = 16'd0;
        rst_n    = 1'b0;
        #1;
        chk("mrst.res", outau, 32'd0);
        chk("mrst.vld", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        chk("mrst.dz", {31'd0, div_by_zero}, 32'd0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk);
        #1;
        chk("mrst.idle", {31'd0, out_valid}, 32'd0);
        chk_op("mrst.first", 3'b001, 16'd10, 16'd3, 32'h0000_0007, 1'b0);

        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
